// File: rtl/ogfx_if_par16_refresh.sv
`default_nettype none
// ============================================================================
// Module   : ogfx_if_par16_refresh
// Purpose  : Display refresh engine. On a frame start it drives a 16-bit
//            8080-style parallel LCD write bus with one memory-write command
//            followed by display_size pixel writes. Pixel words are fetched
//            from the backend through a request/ready handshake. A one-entry
//            prefetch buffer lets the next fetch overlap the current write.
// Ports    : mclk, puc_rst_n            - clock, async active-low reset
//            refresh_start_i            - one-cycle frame start request
//            display_size_i             - pixels per frame (sampled at start)
//            refresh_data_i/_ready_i    - backend pixel word + valid pulse
//            refresh_active_o           - frame in progress
//            refresh_data_request_o     - one-cycle next-pixel request
//            refresh_done_o             - one-cycle end-of-frame pulse
//            lcd_cs_n_o, lcd_rs_o,
//            lcd_wr_n_o, lcd_d_o        - parallel LCD bus
// Revision : 1.0 - initial release
// ============================================================================
module ogfx_if_par16_refresh #(
  parameter int          SPIX_MSB  = 15,
  parameter int          WR_LO_CYC = 1,
  parameter int          WR_HI_CYC = 1,
  parameter logic [15:0] CMD_RAMWR = 16'h002C
) (
  input  logic              mclk,
  input  logic              puc_rst_n,
  input  logic              refresh_start_i,
  input  logic [SPIX_MSB:0] display_size_i,
  input  logic [15:0]       refresh_data_i,
  input  logic              refresh_data_ready_i,
  output logic              refresh_active_o,
  output logic              refresh_data_request_o,
  output logic              refresh_done_o,
  output logic              lcd_cs_n_o,
  output logic              lcd_rs_o,
  output logic              lcd_wr_n_o,
  output logic [15:0]       lcd_d_o
);

  localparam int CNT_W   = SPIX_MSB + 1;
  localparam int CYC_MAX = (WR_LO_CYC > WR_HI_CYC) ? WR_LO_CYC : WR_HI_CYC;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD_LO   = 3'd1,
    ST_CMD_HI   = 3'd2,
    ST_PIX_WAIT = 3'd3,
    ST_DAT_LO   = 3'd4,
    ST_DAT_HI   = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  state_t             state_q,    state_d;
  logic [CYC_W-1:0]   cyc_q,      cyc_d;
  logic [SPIX_MSB:0]  size_q,     size_d;
  logic [SPIX_MSB:0]  req_cnt_q,  req_cnt_d;
  logic [SPIX_MSB:0]  tx_cnt_q,   tx_cnt_d;
  logic [15:0]        buf_q,      buf_d;
  logic               buf_full_q, buf_full_d;
  logic               outst_q,    outst_d;
  logic               cs_n_q,     cs_n_d;
  logic               rs_q,       rs_d;
  logic               wr_n_q,     wr_n_d;
  logic [15:0]        d_q,        d_d;

  logic               w_busy;
  logic               w_req;
  logic               w_accept;
  logic [SPIX_MSB:0]  w_tx_next;
  logic               w_lo_last;
  logic               w_hi_last;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    size_d     = size_q;
    req_cnt_d  = req_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    outst_d    = outst_q;
    cs_n_d     = cs_n_q;
    rs_d       = rs_q;
    wr_n_d     = wr_n_q;
    d_d        = d_q;

    w_busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    // Only one fetch in flight, and only when there is room to land it.
    w_req     = w_busy && !outst_q && !buf_full_q && (req_cnt_q < size_q);
    // Ready is only meaningful against an outstanding request; since a request
    // is issued only with outst_q low, a same-cycle ready is dropped here too.
    w_accept  = refresh_data_ready_i && outst_q;
    w_tx_next = tx_cnt_q + CNT_W'(1);
    w_lo_last = (cyc_q == CYC_W'(WR_LO_CYC - 1));
    w_hi_last = (cyc_q == CYC_W'(WR_HI_CYC - 1));

    if (w_req) begin
      outst_d   = 1'b1;
      req_cnt_d = req_cnt_q + CNT_W'(1);
    end
    if (w_accept) begin
      outst_d    = 1'b0;
      buf_d      = refresh_data_i;
      buf_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (refresh_start_i) begin
          size_d     = display_size_i;
          req_cnt_d  = '0;
          tx_cnt_d   = '0;
          buf_full_d = 1'b0;
          outst_d    = 1'b0;
          cyc_d      = '0;
          cs_n_d     = 1'b0;
          rs_d       = 1'b0;
          wr_n_d     = 1'b0;
          d_d        = CMD_RAMWR;
          state_d    = ST_CMD_LO;
        end
      end
      ST_CMD_LO: begin
        if (w_lo_last) begin
          cyc_d   = '0;
          wr_n_d  = 1'b1;
          state_d = ST_CMD_HI;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_CMD_HI: begin
        if (w_hi_last) begin
          cyc_d = '0;
          if (size_q != '0) begin
            state_d = ST_PIX_WAIT;
          end else begin
            cs_n_d  = 1'b1;
            rs_d    = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_PIX_WAIT: begin
        if (buf_full_q) begin
          d_d        = buf_q;
          buf_full_d = 1'b0;
          rs_d       = 1'b1;
          wr_n_d     = 1'b0;
          cyc_d      = '0;
          state_d    = ST_DAT_LO;
        end else if (w_accept) begin
          // Word arrives while we are already waiting: forward it straight
          // onto the bus so the write starts the next cycle.
          d_d        = refresh_data_i;
          buf_full_d = 1'b0;
          rs_d       = 1'b1;
          wr_n_d     = 1'b0;
          cyc_d      = '0;
          state_d    = ST_DAT_LO;
        end
      end
      ST_DAT_LO: begin
        if (w_lo_last) begin
          cyc_d   = '0;
          wr_n_d  = 1'b1;
          state_d = ST_DAT_HI;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_DAT_HI: begin
        if (w_hi_last) begin
          cyc_d    = '0;
          tx_cnt_d = w_tx_next;
          if (w_tx_next == size_q) begin
            cs_n_d  = 1'b1;
            rs_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_PIX_WAIT;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      size_q     <= '0;
      req_cnt_q  <= '0;
      tx_cnt_q   <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      outst_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      rs_q       <= 1'b1;
      wr_n_q     <= 1'b1;
      d_q        <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      size_q     <= size_d;
      req_cnt_q  <= req_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      outst_q    <= outst_d;
      cs_n_q     <= cs_n_d;
      rs_q       <= rs_d;
      wr_n_q     <= wr_n_d;
      d_q        <= d_d;
    end
  end

  assign refresh_active_o       = (state_q != ST_IDLE);
  assign refresh_done_o         = (state_q == ST_DONE);
  assign refresh_data_request_o = w_req;
  assign lcd_cs_n_o             = cs_n_q;
  assign lcd_rs_o               = rs_q;
  assign lcd_wr_n_o             = wr_n_q;
  assign lcd_d_o                = d_q;

endmodule
`default_nettype wire

// File: tb/tb_ogfx_if_par16_refresh.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ogfx_if_par16_refresh
// Purpose  : Self-checking bench. A frame-level schedule model predicts, from
//            the start cycle, the chosen backend latencies and the write timing
//            rules, every output on every cycle; directed frames also pin the
//            model with hand-computed counts and latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ogfx_if_par16_refresh;

  localparam int          LO   = 1;
  localparam int          HI   = 1;
  localparam int          MAXP = 8;
  localparam logic [15:0] CMD  = 16'h002C;

  logic        mclk = 1'b0;
  logic        puc_rst_n = 1'b0;
  logic        refresh_start_i = 1'b0;
  logic [15:0] display_size_i = '0;
  logic [15:0] refresh_data_i = '0;
  logic        refresh_data_ready_i = 1'b0;
  logic        refresh_active_o, refresh_data_request_o, refresh_done_o;
  logic        lcd_cs_n_o, lcd_rs_o, lcd_wr_n_o;
  logic [15:0] lcd_d_o;

  ogfx_if_par16_refresh #(
    .SPIX_MSB (15),
    .WR_LO_CYC(LO),
    .WR_HI_CYC(HI),
    .CMD_RAMWR(CMD)
  ) dut (
    .mclk                  (mclk),
    .puc_rst_n             (puc_rst_n),
    .refresh_start_i       (refresh_start_i),
    .display_size_i        (display_size_i),
    .refresh_data_i        (refresh_data_i),
    .refresh_data_ready_i  (refresh_data_ready_i),
    .refresh_active_o      (refresh_active_o),
    .refresh_data_request_o(refresh_data_request_o),
    .refresh_done_o        (refresh_done_o),
    .lcd_cs_n_o            (lcd_cs_n_o),
    .lcd_rs_o              (lcd_rs_o),
    .lcd_wr_n_o            (lcd_wr_n_o),
    .lcd_d_o               (lcd_d_o)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- frame schedule model ----------------
  bit          fv = 0;      // a frame has been accepted since last reset
  bit          in_rst = 1;
  int          t_f, d_f, sz_f;
  int          r_t [1:MAXP];
  int          a_t [1:MAXP];
  int          s_t [1:MAXP];
  logic [15:0] dat [1:MAXP];
  int          lat_n [1:MAXP];
  logic [15:0] dat_n [1:MAXP];
  logic [15:0] idle_d = '0;

  function automatic bit model_idle(input int c);
    return !fv || (c > d_f);
  endfunction

  function automatic logic [15:0] exp_d_at(input int c);
    if (!fv || c <= t_f) return idle_d;
    if (sz_f == 0 || c < s_t[1]) return CMD;
    for (int i = MAXP; i >= 1; i--)
      if (i <= sz_f && c >= s_t[i]) return dat[i];
    return CMD;
  endfunction

  function automatic bit outstanding_at(input int c);
    if (!fv) return 0;
    for (int i = 1; i <= sz_f; i++)
      if (c >= r_t[i] + 1 && c <= a_t[i]) return 1;
    return 0;
  endfunction

  // Timeline: command write occupies T+1..T+LO+HI. Pixel i waits one
  // PIX_WAIT cycle after the previous write, or for its ready if later, then
  // writes for LO+HI cycles. The next fetch is requested as pixel i's write
  // begins. Done is the cycle after the last write.
  task automatic accept(input int c, input int sz);
    int e, rc;
    idle_d = exp_d_at(c);
    fv = 1; t_f = c; sz_f = sz;
    e = c + LO + HI; rc = c + 1;
    for (int i = 1; i <= sz; i++) begin
      r_t[i] = rc;
      a_t[i] = rc + lat_n[i];
      s_t[i] = (((e + 1) > a_t[i]) ? (e + 1) : a_t[i]) + 1;
      e      = s_t[i] + LO + HI - 1;
      rc     = s_t[i];
      dat[i] = dat_n[i];
    end
    d_f = e + 1;
  endtask

  // ---------------- per-cycle compare + observation monitor ----------------
  int          mon_req, mon_wrlo, mon_done, done_cyc;
  logic [15:0] words [$];
  logic [15:0] lo_d;
  logic        prev_wr = 1'b1;

  task automatic mon_clear();
    mon_req = 0; mon_wrlo = 0; mon_done = 0; done_cyc = -1;
    words.delete();
  endtask

  always @(negedge mclk) begin
    int  c;
    bit  e_act, e_req, e_done, e_cs, e_rs, e_wr;
    c = cyc;
    if (in_rst) begin
      e_act = 0; e_req = 0; e_done = 0; e_cs = 1; e_rs = 1; e_wr = 1;
      chk("d", 32'(lcd_d_o), 32'h0);
    end else begin
      e_act  = fv && c >= t_f + 1 && c <= d_f;
      e_done = fv && c == d_f;
      e_cs   = !(fv && c >= t_f + 1 && c <= d_f - 1);
      e_rs   = !(fv && c >= t_f + 1 && c < ((sz_f > 0) ? s_t[1] : d_f));
      e_wr   = !(fv && c >= t_f + 1 && c <= t_f + LO);
      e_req  = 0;
      if (fv)
        for (int i = 1; i <= sz_f; i++) begin
          if (c == r_t[i]) e_req = 1;
          if (c >= s_t[i] && c <= s_t[i] + LO - 1) e_wr = 0;
        end
      chk("d", 32'(lcd_d_o), 32'(exp_d_at(c)));
    end
    chk("active", 32'(refresh_active_o), 32'(e_act));
    chk("request", 32'(refresh_data_request_o), 32'(e_req));
    chk("done", 32'(refresh_done_o), 32'(e_done));
    chk("cs_n", 32'(lcd_cs_n_o), 32'(e_cs));
    chk("rs", 32'(lcd_rs_o), 32'(e_rs));
    chk("wr_n", 32'(lcd_wr_n_o), 32'(e_wr));

    if (refresh_data_request_o) mon_req++;
    if (refresh_done_o) begin mon_done++; done_cyc = c; end
    if (prev_wr && !lcd_wr_n_o) mon_wrlo++;
    if (!lcd_wr_n_o) lo_d = lcd_d_o;
    if (!prev_wr && lcd_wr_n_o && !in_rst) words.push_back(lo_d);
    prev_wr = lcd_wr_n_o;
  end

  // ---------------- stimulus ----------------
  task automatic rand_frame_params();
    for (int i = 1; i <= MAXP; i++) begin
      lat_n[i] = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(1, 5));
      dat_n[i] = 16'($urandom);
    end
  endtask

  task automatic drive_cycle(input bit force_st, input int fsz, input bit rnd_st, input bit noise);
    int  c, sz;
    bit  st, rdy, hit;
    logic [15:0] dv;
    @(posedge mclk); #1;
    c = cyc; st = 0; rdy = 0; hit = 0;
    sz = int'($urandom_range(0, 65535));
    dv = 16'($urandom);
    if (in_rst) begin
      st  = 1'($urandom);
      rdy = 1'($urandom);
    end else begin
      if (model_idle(c)) begin
        if (force_st) begin
          st = 1; sz = fsz; accept(c, fsz);
        end else if (rnd_st && $urandom_range(0, 2) == 0) begin
          rand_frame_params();
          sz = int'($urandom_range(0, 6));
          st = 1; accept(c, sz);
        end
      end else if (noise && $urandom_range(0, 4) == 0) begin
        st = 1;   // mid-frame start with a wild size: must be ignored
      end
      if (fv)
        for (int i = 1; i <= sz_f; i++)
          if (a_t[i] == c) begin rdy = 1; dv = dat[i]; hit = 1; end
      if (!hit && noise && !outstanding_at(c) && $urandom_range(0, 3) == 0)
        rdy = 1;  // unsolicited ready: must not touch buffer or bus
    end
    refresh_start_i      = st;
    display_size_i       = 16'(sz);
    refresh_data_ready_i = rdy;
    refresh_data_i       = dv;
  endtask

  task automatic run_until_idle(input bit noise);
    for (int k = 0; k < 600; k++) begin
      drive_cycle(0, 0, 0, noise);
      if (model_idle(cyc) && (!fv || cyc > d_f + 2)) return;
    end
    chk("idle_timeout", 32'(1), 32'(0));
  endtask

  task automatic run_frame(input int sz, input bit noise, output int t0);
    mon_clear();
    drive_cycle(1, sz, 0, noise);
    t0 = t_f;
    run_until_idle(noise);
  endtask

  task automatic release_reset();
    @(posedge mclk); #1;
    puc_rst_n = 1'b1; in_rst = 0;
    refresh_start_i = 0; refresh_data_ready_i = 0;
  endtask

  task automatic chk_words(input int n, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] ex [4];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    chk("nwords", 32'(words.size()), 32'(n));
    for (int i = 0; i < n; i++)
      chk($sformatf("word%0d", i), (i < words.size()) ? 32'(words[i]) : 32'hxxxx_xxxx, 32'(ex[i]));
  endtask

  initial begin
    int t0;
    mon_clear();
    // Reset with inputs toggling.
    for (int k = 0; k < 6; k++) drive_cycle(0, 0, 0, 0);
    release_reset();
    drive_cycle(0, 0, 0, 0);

    // Size 3, latency 2: done at T+12, 3 requests, 4 write strobes.
    for (int i = 1; i <= MAXP; i++) lat_n[i] = 2;
    dat_n[1] = 16'h1111; dat_n[2] = 16'h2222; dat_n[3] = 16'h3333;
    run_frame(3, 0, t0);
    chk("f3_req", 32'(mon_req), 32'd3);
    chk("f3_wrlo", 32'(mon_wrlo), 32'd4);
    chk("f3_done", 32'(mon_done), 32'd1);
    chk("f3_done_lat", 32'(done_cyc - t0), 32'd12);
    chk_words(4, CMD, 16'h1111, 16'h2222, 16'h3333);

    // Size 0: only the command write, done at T+3.
    run_frame(0, 0, t0);
    chk("f0_req", 32'(mon_req), 32'd0);
    chk("f0_wrlo", 32'(mon_wrlo), 32'd1);
    chk("f0_done", 32'(mon_done), 32'd1);
    chk("f0_done_lat", 32'(done_cyc - t0), 32'd3);
    chk_words(1, CMD, 16'h0, 16'h0, 16'h0);

    // Slow backend, latency 12, size 2: done at T+29.
    for (int i = 1; i <= MAXP; i++) lat_n[i] = 12;
    dat_n[1] = 16'hA5A5; dat_n[2] = 16'h5A5A;
    run_frame(2, 0, t0);
    chk("slow_req", 32'(mon_req), 32'd2);
    chk("slow_wrlo", 32'(mon_wrlo), 32'd3);
    chk("slow_done_lat", 32'(done_cyc - t0), 32'd29);
    chk_words(3, CMD, 16'hA5A5, 16'h5A5A, 16'h0);

    // Mid-frame starts and unsolicited readies.
    for (int i = 1; i <= MAXP; i++) lat_n[i] = 3;
    dat_n[1] = 16'hBEEF; dat_n[2] = 16'hCAFE; dat_n[3] = 16'h0F0F;
    run_frame(3, 1, t0);
    chk("noise_req", 32'(mon_req), 32'd3);
    chk("noise_done", 32'(mon_done), 32'd1);
    chk_words(4, CMD, 16'hBEEF, 16'hCAFE, 16'h0F0F);

    // Reset during DAT_LO of pixel 2 of 5, then a 1-pixel frame.
    for (int i = 1; i <= MAXP; i++) begin lat_n[i] = 1; dat_n[i] = 16'(16'h0100 + i); end
    mon_clear();
    drive_cycle(1, 5, 0, 0);
    for (int k = 0; k < 100 && cyc != s_t[2]; k++) drive_cycle(0, 0, 0, 0);
    #2;
    puc_rst_n = 1'b0; in_rst = 1; fv = 0; idle_d = '0;
    for (int k = 0; k < 3; k++) drive_cycle(0, 0, 0, 0);
    chk("rst_no_done", 32'(mon_done), 32'd0);
    release_reset();
    drive_cycle(0, 0, 0, 0);
    lat_n[1] = 2; dat_n[1] = 16'h7E57;
    run_frame(1, 0, t0);
    chk("p1_req", 32'(mon_req), 32'd1);
    chk("p1_done", 32'(mon_done), 32'd1);
    chk("p1_done_lat", 32'(done_cyc - t0), 32'd6);
    chk_words(2, CMD, 16'h7E57, 16'h0, 16'h0);

    // Randomized frames with noise.
    for (int k = 0; k < 2000; k++) drive_cycle(0, 0, 1, 1);
    run_until_idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
